wb_skid_stage: RTL

Parametrised MEM→WB pipeline stage register. It carries the write-back control bits, destination register address, memory address/ALU result and memory read data from the memory stage to write-back. It adds a valid/ready handshake with a two-entry skid buffer, plus synchronous flush and bubble insertion. It replaces the fixed-width, always-advancing stage register between data memory and the register-file write port, and sits on the same single clock.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_slot.sv | 41 ++++
 rtl/wb_skid_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the MEM->WB stage: control bit indices, stage state
// encoding and the default-width write-back entry layout.
package wb_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEM2REG  = 1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_CTRL_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_RD_W-1:0]   rd;
    logic [DEF_DATA_W-1:0] addr;
    logic [DEF_DATA_W-1:0] rdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_slot.sv
// One holding slot: payload register with load enable plus a valid flag
// with set/clear (set wins). Payload is never cleared except by reset.
module wb_slot
  import wb_pkg::*;
#(
  parameter int W = 71
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         set,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = load ? d : data_q;
    valid_d = valid_q;
    if (set)      valid_d = 1'b1;
    else if (clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/wb_skid_stage.sv
// MEM->WB pipeline register with valid/ready handshake, two-entry skid
// buffer, synchronous flush and bubble masking of the write-back controls.
module wb_skid_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_rdata,
  output logic [1:0]        occupancy,
  output wb_state_e         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and in_ready is a pure flop output.

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } entry_t;

  localparam int EW = $bits(entry_t);

  wb_state_e state_q, state_d;
  entry_t    in_entry, main_q, skid_q, main_d;
  logic      main_valid, skid_valid;
  logic      main_load, main_set, main_clr, main_sel_skid;
  logic      skid_load, skid_set, skid_clr;
  logic      in_fire, out_fire;

  assign in_entry = '{ctrl: in_ctrl, rd: in_rd, addr: in_addr, rdata: in_rdata};
  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_set      = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_set      = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      // Drops held entries and any same-cycle input; payloads left as-is.
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            main_set  = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            skid_set  = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
            state_d       = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    main_d = main_sel_skid ? skid_q : in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  wb_slot #(.W(EW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .set   (main_set),
    .clr   (main_clr),
    .q     (main_q),
    .valid (main_valid)
  );

  wb_slot #(.W(EW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_entry),
    .set   (skid_set),
    .clr   (skid_clr),
    .q     (skid_q),
    .valid (skid_valid)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_q.ctrl & {CTRL_W{main_valid}};
  assign out_rd    = main_q.rd;
  assign out_addr  = main_q.addr;
  assign out_rdata = main_q.rdata;
  assign occupancy = {skid_valid, main_valid & ~skid_valid};
  assign dbg_state = state_q;

endmodule
